int_ack_sequencer: RTL and testbench
====================================

INT_ACK_SEQUENCER -- requirements
Module: int_ack_sequencer

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of request lines (fixed at 8 in this release).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port IR  in  8  level request lines, already synchronized to clk.
REQ-005 SHALL have port IMR  in  8  mask; bit=1 masks IR[i] from resolution only, not from IRR.
REQ-006 SHALL have port vec_base  in  5  vector bits T7..T3.
REQ-007 SHALL have port rotate_en  in  1  1=rotating priority, 0=fixed (IR0 highest).
REQ-008 SHALL have port auto_eoi  in  1  1=clear ISR bit automatically at end of acknowledge.
REQ-009 SHALL have port eoi  in  1  one-cycle non-specific EOI pulse.
REQ-010 SHALL have port INTA  in  1  active-low CPU acknowledge, synchronous to clk.
REQ-011 SHALL have port INT  out  1  interrupt request to CPU.
REQ-012 SHALL have port data_out  out  8  vector {vec_base, level[2:0]}.
REQ-013 SHALL have port data_oe  out  1  data_out valid/drive enable.
REQ-014 SHALL have ports IRR, ISR  out  8 each  request and in-service registers.

Function
REQ-015 SHALL register INTA and detect falling edge (prev=1, cur=0) and rising edge (prev=0, cur=1); a low level persisting across cycles counts once.
REQ-016 SHALL set IRR[i] the cycle after IR[i]=1 and clear it the cycle after IR[i]=0, unless cleared by acknowledge (REQ-020).
REQ-017 SHALL compute candidate = highest-priority bit of IRR & ~IMR whose priority exceeds every set ISR bit; none if no such bit.
REQ-018 SHALL use priority order, fixed: 0 highest .. 7 lowest; rotating: level (lowest_ptr+1) mod 8 highest, lowest_ptr lowest, with lowest_ptr wrapping 7->0.
REQ-019 SHALL implement FSM IDLE -> PEND -> ACK1 -> ACK2 -> IDLE: IDLE->PEND when candidate exists; PEND->ACK1 on INTA falling edge; ACK1->ACK2 on next INTA falling edge; ACK2->IDLE on INTA rising edge.
REQ-020 SHALL, on PEND->ACK1 transition, freeze the candidate as level, set ISR[level], clear IRR[level], and deassert INT.
REQ-021 SHALL, if no candidate exists at the first INTA falling edge (request withdrawn), take level=7 as spurious and leave ISR/IRR unchanged.
REQ-022 SHALL assert INT in PEND only; INT rises one cycle after the candidate appears; PEND->IDLE without acknowledge when candidate disappears.
REQ-023 SHALL drive data_oe=1 and data_out={vec_base,level} while in ACK2 and INTA=0; otherwise data_oe=0, data_out=8'h00.
REQ-024 SHALL, in ACK2 rising edge with auto_eoi=1 and non-spurious, clear ISR[level] and, if rotate_en=1, set lowest_ptr=level.
REQ-025 SHALL, on eoi=1, clear highest-priority set ISR bit and, if rotate_en=1, set lowest_ptr to that level; ignored when ISR=0.
REQ-026 SHALL, when eoi and an ISR set coincide, apply both; clear selects from ISR before the set.
REQ-027 SHALL ignore INTA falling edges in IDLE (no state change, data_oe=0).

Reset
REQ-028 SHALL, on rst_n=0 (any state, mid-sequence included), immediately force: FSM=IDLE, IRR=0, ISR=0, INT=0, data_oe=0, data_out=0, lowest_ptr=7, INTA history=1.
REQ-029 SHALL resume normal operation on the first rising clk after rst_n deasserts.

Structure
REQ-030 SHALL place FSM state encoding, N_IRQ, and vector width constants in shared package int_ctrl_pkg.
REQ-031 SHALL instantiate one combinational sub-module priority_resolver (inputs: request vector, ISR, lowest_ptr, rotate_en; outputs: valid, level[2:0]), reused for both candidate and EOI selection.

Verification
REQ-032 Fixed priority: IR=8'b0010_0100, IMR=0, vec_base=5'b10000 -> INT=1; two INTA pulses -> data_out=8'h82, ISR=8'h04, IRR=8'h20.
REQ-033 Nesting: ISR=8'h04, IR[5] raised -> INT stays 0; IR[1] raised -> INT=1, ack gives level 1, ISR=8'h06.
REQ-034 Rotation: rotate_en=1, service IR3, eoi pulse -> lowest_ptr=3; IR3 and IR4 both raised -> IR4 wins.
REQ-035 Spurious: IR[2] pulsed high then low before first INTA falling edge -> vector {vec_base,3'b111}, ISR unchanged.
REQ-036 auto_eoi=1: full ack of IR6 -> ISR=0 after INTA rising edge in ACK2; eoi with ISR=0 -> no change.
REQ-037 Reset in ACK1: rst_n=0 -> all outputs per REQ-028 same cycle; pending IR re-raises INT two cycles after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants and FSM encoding for the interrupt acknowledge sequencer.
package int_ctrl_pkg;
  localparam int N_IRQ  = 8;
  localparam int LVL_W  = 3;
  localparam int VEC_W  = 5;
  localparam int DATA_W = VEC_W + LVL_W;

  localparam logic [LVL_W-1:0] PTR_RESET    = 3'd7;
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK1 = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;
endpackage

// File: rtl/int_ack_sequencer_if.sv
// CPU acknowledge bus: interrupt request out, INTA strobe in, vector back.
interface int_ack_sequencer_if;
  import int_ctrl_pkg::*;

  logic              INTA;
  logic              INT;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;

  modport master (input INTA, output INT, output data_out, output data_oe);
  modport slave  (output INTA, input INT, input data_out, input data_oe);
endinterface

// File: rtl/priority_resolver.sv
// Picks the highest-priority request that outranks every in-service level.
module priority_resolver
  import int_ctrl_pkg::*;
(
  input  logic [N_IRQ-1:0] req,
  input  logic [N_IRQ-1:0] isr,
  input  logic [LVL_W-1:0] lowest_ptr,
  input  logic             rotate_en,
  output logic             valid,
  output logic [LVL_W-1:0] level
);
  logic [LVL_W-1:0] start;
  logic [N_IRQ-1:0] req_rot;
  logic [N_IRQ-1:0] isr_rot;
  logic             req_hit;
  logic             isr_hit;
  logic [LVL_W-1:0] req_rank;
  logic [LVL_W-1:0] isr_rank;

  assign start = rotate_en ? lowest_ptr + LVL_W'(1) : '0;

  // Rank 0 of the rotated vectors is always the current highest-priority level.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi = gi + 1) begin : g_rot
      logic [LVL_W-1:0] idx;
      assign idx         = start + LVL_W'(gi);
      assign req_rot[gi] = req[idx];
      assign isr_rot[gi] = isr[idx];
    end
  endgenerate

  always_comb begin
    req_hit  = 1'b0;
    isr_hit  = 1'b0;
    req_rank = '0;
    isr_rank = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        req_hit  = 1'b1;
        req_rank = LVL_W'(k);
      end
      if (isr_rot[k]) begin
        isr_hit  = 1'b1;
        isr_rank = LVL_W'(k);
      end
    end
  end

  assign valid = req_hit && (!isr_hit || (req_rank < isr_rank));
  assign level = start + req_rank;
endmodule

// File: rtl/int_ack_sequencer.sv
// Interrupt request/acknowledge sequencer: IRR/ISR tracking, priority, two-pulse INTA vectoring.
module int_ack_sequencer #(
  parameter int N_IRQ = int_ctrl_pkg::N_IRQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_IRQ-1:0]              IR,
  input  logic [N_IRQ-1:0]              IMR,
  input  logic [int_ctrl_pkg::VEC_W-1:0] vec_base,
  input  logic                          rotate_en,
  input  logic                          auto_eoi,
  input  logic                          eoi,
  output logic [N_IRQ-1:0]              IRR,
  output logic [N_IRQ-1:0]              ISR,
  int_ack_sequencer_if.master           bus
);
  import int_ctrl_pkg::LVL_W;
  import int_ctrl_pkg::DATA_W;
  import int_ctrl_pkg::PTR_RESET;
  import int_ctrl_pkg::SPURIOUS_LVL;
  import int_ctrl_pkg::state_t;
  import int_ctrl_pkg::ST_IDLE;
  import int_ctrl_pkg::ST_PEND;
  import int_ctrl_pkg::ST_ACK1;
  import int_ctrl_pkg::ST_ACK2;

  state_t             state_reg;
  logic [N_IRQ-1:0]   irr_reg;
  logic [N_IRQ-1:0]   isr_reg;
  logic [N_IRQ-1:0]   hold_reg;
  logic [LVL_W-1:0]   lowest_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic               spurious_reg;
  logic               inta_prev_reg;
  logic               int_reg;
  logic               data_oe_reg;
  logic [DATA_W-1:0]  data_out_reg;

  logic               inta_fall;
  logic               inta_rise;
  logic               cand_valid;
  logic [LVL_W-1:0]   cand_level;
  logic               eoi_valid;
  logic [LVL_W-1:0]   eoi_level;
  logic               auto_clr;
  logic [N_IRQ-1:0]   set_mask;
  logic [N_IRQ-1:0]   clr_mask;
  logic [N_IRQ-1:0]   hold_next;

  assign inta_fall = inta_prev_reg & ~bus.INTA;
  assign inta_rise = ~inta_prev_reg & bus.INTA;

  priority_resolver u_cand (
    .req        (irr_reg & ~IMR),
    .isr        (isr_reg),
    .lowest_ptr (lowest_ptr_reg),
    .rotate_en  (rotate_en),
    .valid      (cand_valid),
    .level      (cand_level)
  );

  priority_resolver u_eoi (
    .req        (isr_reg),
    .isr        ('0),
    .lowest_ptr (lowest_ptr_reg),
    .rotate_en  (rotate_en),
    .valid      (eoi_valid),
    .level      (eoi_level)
  );

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    auto_clr = (state_reg == ST_ACK2) && inta_rise && auto_eoi && !spurious_reg;
    if ((state_reg == ST_PEND) && inta_fall && cand_valid) set_mask[cand_level] = 1'b1;
    if (auto_clr)                                          clr_mask[level_reg]  = 1'b1;
    if (eoi && eoi_valid)                                  clr_mask[eoi_level]  = 1'b1;
    // An acknowledged level stays out of IRR until its IR line has dropped once.
    hold_next = (hold_reg | set_mask) & IR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      irr_reg        <= '0;
      isr_reg        <= '0;
      hold_reg       <= '0;
      lowest_ptr_reg <= PTR_RESET;
      level_reg      <= '0;
      spurious_reg   <= 1'b0;
      inta_prev_reg  <= 1'b1;
      int_reg        <= 1'b0;
      data_oe_reg    <= 1'b0;
      data_out_reg   <= '0;
    end else begin
      inta_prev_reg <= bus.INTA;
      hold_reg      <= hold_next;
      irr_reg       <= IR & ~hold_next;
      isr_reg       <= (isr_reg & ~clr_mask) | set_mask;
      if (auto_clr && rotate_en)                   lowest_ptr_reg <= level_reg;
      else if (eoi && eoi_valid && rotate_en)      lowest_ptr_reg <= eoi_level;

      case (state_reg)
        ST_IDLE: begin
          if (cand_valid) begin
            state_reg <= ST_PEND;
            int_reg   <= 1'b1;
          end
        end
        ST_PEND: begin
          if (inta_fall) begin
            state_reg    <= ST_ACK1;
            int_reg      <= 1'b0;
            spurious_reg <= !cand_valid;
            level_reg    <= cand_valid ? cand_level : SPURIOUS_LVL;
          end else if (!cand_valid) begin
            state_reg <= ST_IDLE;
            int_reg   <= 1'b0;
          end
        end
        ST_ACK1: begin
          if (inta_fall) begin
            state_reg    <= ST_ACK2;
            data_oe_reg  <= 1'b1;
            data_out_reg <= {vec_base, level_reg};
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state_reg    <= ST_IDLE;
            data_oe_reg  <= 1'b0;
            data_out_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign IRR          = irr_reg;
  assign ISR          = isr_reg;
  assign bus.INT      = int_reg;
  assign bus.data_oe  = data_oe_reg;
  assign bus.data_out = data_out_reg;
endmodule

// File: tb/tb_int_ack_sequencer.sv
// Self-checking bench: vector table, directed corner sequences, randomized run against a rank-based model.
module tb_int_ack_sequencer;
  logic       clk;
  logic       rst_n;
  logic [7:0] IR;
  logic [7:0] IMR;
  logic [4:0] vec_base;
  logic       rotate_en;
  logic       auto_eoi;
  logic       eoi;
  logic [7:0] IRR;
  logic [7:0] ISR;

  int n_checks = 0;
  int n_errors = 0;

  int_ack_sequencer_if bus ();

  int_ack_sequencer #(.N_IRQ(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IR        (IR),
    .IMR       (IMR),
    .vec_base  (vec_base),
    .rotate_en (rotate_en),
    .auto_eoi  (auto_eoi),
    .eoi       (eoi),
    .IRR       (IRR),
    .ISR       (ISR),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] imr;
    logic [4:0] vb;
    logic       exp_int;
    logic [7:0] exp_vec;
    logic [2:0] exp_lvl;
  } vec_t;

  vec_t tbl [8];

  // Reference model state: priority is expressed as a rank (0 = served first).
  logic [7:0] m_irr, m_isr, m_hold, m_dout;
  int         m_ptr, m_phase, m_level;
  bit         m_spur, m_int, m_oe, m_inta_prev;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    IR        = '0;
    IMR       = '0;
    eoi       = 1'b0;
    rotate_en = 1'b0;
    auto_eoi  = 1'b0;
    vec_base  = '0;
    bus.INTA  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // CPU side of a full acknowledge: two INTA low pulses, vector sampled in the second.
  task automatic cpu_ack(output logic [7:0] vec, output logic oe);
    bus.INTA = 1'b0;
    tick();
    tick();
    bus.INTA = 1'b1;
    tick();
    bus.INTA = 1'b0;
    tick();
    vec = bus.data_out;
    oe  = bus.data_oe;
    tick();
    bus.INTA = 1'b1;
    tick();
  endtask

  function automatic int rank(int i, bit rot, int ptr);
    return rot ? ((i - ptr - 1 + 16) % 8) : i;
  endfunction

  function automatic void pick(input logic [7:0] req, input logic [7:0] blk, input bit rot,
                               input int ptr, output bit ok, output int lvl);
    int best_req;
    int best_blk;
    best_req = 8;
    best_blk = 8;
    lvl      = 7;
    for (int i = 0; i < 8; i++) begin
      if (req[i] && rank(i, rot, ptr) < best_req) begin
        best_req = rank(i, rot, ptr);
        lvl      = i;
      end
      if (blk[i] && rank(i, rot, ptr) < best_blk) best_blk = rank(i, rot, ptr);
    end
    ok = best_req < best_blk;
  endfunction

  function automatic void model_reset();
    m_irr = '0; m_isr = '0; m_hold = '0; m_dout = '0;
    m_ptr = 7; m_phase = 0; m_level = 0;
    m_spur = 0; m_int = 0; m_oe = 0; m_inta_prev = 1;
  endfunction

  // Predicts the state after the next rising edge from the inputs now applied.
  function automatic void model_step(input logic [7:0] ir, input logic [7:0] imr, input logic [4:0] vb,
                                     input bit rot, input bit aeoi, input bit e, input bit inta);
    bit fall, rise, cv, ev;
    int cl, el, ptr_n;
    logic [7:0] set_m, clr_m, hold_n;
    fall  = m_inta_prev && !inta;
    rise  = !m_inta_prev && inta;
    pick(m_irr & ~imr, m_isr, rot, m_ptr, cv, cl);
    pick(m_isr, 8'h00, rot, m_ptr, ev, el);
    set_m = '0;
    clr_m = '0;
    ptr_n = m_ptr;
    if (e && ev) begin
      clr_m[el] = 1'b1;
      if (rot) ptr_n = el;
    end
    case (m_phase)
      0: if (cv) begin m_phase = 1; m_int = 1; end
      1: begin
        if (fall) begin
          m_phase = 2; m_int = 0; m_spur = !cv;
          m_level = cv ? cl : 7;
          if (cv) set_m[cl] = 1'b1;
        end else if (!cv) begin
          m_phase = 0; m_int = 0;
        end
      end
      2: if (fall) begin m_phase = 3; m_oe = 1; m_dout = {vb, 3'(m_level)}; end
      default: begin
        if (rise) begin
          m_phase = 0; m_oe = 0; m_dout = '0;
          if (aeoi && !m_spur) begin
            clr_m[m_level] = 1'b1;
            if (rot) ptr_n = m_level;
          end
        end
      end
    endcase
    hold_n      = (m_hold | set_m) & ir;
    m_hold      = hold_n;
    m_irr       = ir & ~hold_n;
    m_isr       = (m_isr & ~clr_m) | set_m;
    m_ptr       = ptr_n;
    m_inta_prev = inta;
  endfunction

  initial begin
    logic [7:0] v;
    logic       oe;
    bit         prev_oe;

    tbl[0] = '{8'h24, 8'h00, 5'b10000, 1'b1, 8'h82, 3'd2};
    tbl[1] = '{8'h24, 8'h04, 5'b10000, 1'b1, 8'h85, 3'd5};
    tbl[2] = '{8'h80, 8'h80, 5'b10000, 1'b0, 8'h00, 3'd0};
    tbl[3] = '{8'h00, 8'h00, 5'b11111, 1'b0, 8'h00, 3'd0};
    tbl[4] = '{8'hF0, 8'h10, 5'b11111, 1'b1, 8'hFD, 3'd5};
    tbl[5] = '{8'h01, 8'h00, 5'b00000, 1'b1, 8'h00, 3'd0};
    tbl[6] = '{8'hFF, 8'hFE, 5'b01100, 1'b1, 8'h60, 3'd0};
    tbl[7] = '{8'h81, 8'h01, 5'b01010, 1'b1, 8'h57, 3'd7};

    rst_n = 1'b0;
    bus.INTA = 1'b1;
    @(negedge clk);

    // Table-driven vectors, fixed priority, each from a clean reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      check($sformatf("v%0d rst INT", i), 8'(bus.INT), 8'd0);
      check($sformatf("v%0d rst oe", i), 8'(bus.data_oe), 8'd0);
      check($sformatf("v%0d rst dout", i), bus.data_out, 8'h00);
      check($sformatf("v%0d rst ISR", i), ISR, 8'h00);
      IR       = tbl[i].ir;
      IMR      = tbl[i].imr;
      vec_base = tbl[i].vb;
      tick(); tick(); tick();
      check($sformatf("v%0d INT", i), 8'(bus.INT), 8'(tbl[i].exp_int));
      if (tbl[i].exp_int) begin
        cpu_ack(v, oe);
        check($sformatf("v%0d oe", i), 8'(oe), 8'd1);
        check($sformatf("v%0d vec", i), v, tbl[i].exp_vec);
        check($sformatf("v%0d ISR", i), ISR, 8'(8'h01 << tbl[i].exp_lvl));
        check($sformatf("v%0d IRR", i), IRR, tbl[i].ir & ~(8'h01 << tbl[i].exp_lvl));
        check($sformatf("v%0d oe after", i), 8'(bus.data_oe), 8'd0);
      end else begin
        v = 8'h00;
      end
      $display("vector %0d: IR=%02h IMR=%02h INT=%0b vec=%02h ISR=%02h IRR=%02h",
               i, tbl[i].ir, tbl[i].imr, bus.INT, v, ISR, IRR);
    end

    // Nesting: lower-priority request blocked, higher-priority one nests.
    do_reset();
    IR = 8'h04;
    tick(); tick();
    cpu_ack(v, oe);
    check("nest first vec", v, 8'h02);
    IR = 8'h24;
    tick(); tick(); tick();
    check("nest IR5 blocked INT", 8'(bus.INT), 8'd0);
    IR = 8'h26;
    tick(); tick(); tick();
    check("nest IR1 INT", 8'(bus.INT), 8'd1);
    cpu_ack(v, oe);
    check("nest IR1 vec", v, 8'h01);
    check("nest ISR", ISR, 8'h06);
    $display("nesting: vec=%02h ISR=%02h", v, ISR);

    // Rotation: servicing IR3 then EOI makes IR4 the highest priority.
    do_reset();
    rotate_en = 1'b1;
    IR = 8'h08;
    tick(); tick();
    cpu_ack(v, oe);
    check("rot IR3 vec", v, 8'h03);
    IR  = 8'h00;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("rot eoi ISR", ISR, 8'h00);
    IR = 8'h18;
    tick(); tick(); tick();
    cpu_ack(v, oe);
    check("rot IR4 wins", v, 8'h04);
    check("rot ISR", ISR, 8'h10);
    $display("rotation: vec=%02h ISR=%02h", v, ISR);

    // Spurious: request withdrawn before the first INTA falling edge.
    do_reset();
    vec_base = 5'b10101;
    IR = 8'h04;
    tick(); tick();
    check("spur INT", 8'(bus.INT), 8'd1);
    IR = 8'h00;
    tick();
    cpu_ack(v, oe);
    check("spur vec", v, 8'hAF);
    check("spur ISR", ISR, 8'h00);
    $display("spurious: vec=%02h ISR=%02h", v, ISR);

    // Auto-EOI clears ISR at the end of acknowledge; EOI with empty ISR does nothing.
    do_reset();
    auto_eoi = 1'b1;
    IR = 8'h40;
    tick(); tick();
    cpu_ack(v, oe);
    check("aeoi vec", v, 8'h06);
    check("aeoi ISR", ISR, 8'h00);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    check("aeoi eoi ISR", ISR, 8'h00);
    check("aeoi eoi IRR", IRR, 8'h00);
    check("aeoi eoi INT", 8'(bus.INT), 8'd0);
    $display("auto_eoi: vec=%02h ISR=%02h", v, ISR);

    // INTA held low in IDLE must not count as a falling edge later.
    do_reset();
    bus.INTA = 1'b0;
    tick(); tick(); tick();
    check("idle inta oe", 8'(bus.data_oe), 8'd0);
    IR = 8'h02;
    tick(); tick(); tick();
    check("idle inta held INT", 8'(bus.INT), 8'd1);
    bus.INTA = 1'b1;
    tick();
    cpu_ack(v, oe);
    check("idle inta vec", v, 8'h01);
    $display("inta idle: vec=%02h", v);

    // Reset asserted in ACK1 takes effect immediately.
    do_reset();
    IR = 8'h10;
    tick(); tick();
    check("rst1 INT", 8'(bus.INT), 8'd1);
    bus.INTA = 1'b0;
    tick();
    check("rst1 ack ISR", ISR, 8'h10);
    rst_n = 1'b0;
    #1;
    check("rst1 async INT", 8'(bus.INT), 8'd0);
    check("rst1 async oe", 8'(bus.data_oe), 8'd0);
    check("rst1 async dout", bus.data_out, 8'h00);
    check("rst1 async ISR", ISR, 8'h00);
    check("rst1 async IRR", IRR, 8'h00);
    bus.INTA = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst1 release+1 INT", 8'(bus.INT), 8'd0);
    tick();
    check("rst1 release+2 INT", 8'(bus.INT), 8'd1);
    $display("reset in ACK1: INT=%0b", bus.INT);

    // Randomized run against the reference model, all rotate/auto-EOI combinations.
    do_reset();
    model_reset();
    prev_oe = 0;
    for (int b = 0; b < 4; b++) begin
      rotate_en = b[0];
      auto_eoi  = b[1];
      vec_base  = 5'($urandom);
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 7) == 0) IR[$urandom_range(0, 7)] = ~IR[$urandom_range(0, 7)];
        if ($urandom_range(0, 39) == 0) IMR = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 3) == 0) bus.INTA = ~bus.INTA;
        eoi = ($urandom_range(0, 11) == 0);
        model_step(IR, IMR, vec_base, rotate_en, auto_eoi, eoi, bus.INTA);
        tick();
        check($sformatf("rand b%0d c%0d INT", b, c), 8'(bus.INT), 8'(m_int));
        check($sformatf("rand b%0d c%0d oe", b, c), 8'(bus.data_oe), 8'(m_oe));
        check($sformatf("rand b%0d c%0d dout", b, c), bus.data_out, m_dout);
        check($sformatf("rand b%0d c%0d IRR", b, c), IRR, m_irr);
        check($sformatf("rand b%0d c%0d ISR", b, c), ISR, m_isr);
        if (m_oe && !prev_oe)
          $display("random ack: rot=%0b aeoi=%0b vec=%02h ISR=%02h", rotate_en, auto_eoi, m_dout, m_isr);
        prev_oe = m_oe;
      end
    end
    eoi = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
